// File: rtl/otter_dmem_arbiter.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency data RAM.
// Issues at most one access per cycle and steers read data back to its issuer.
module otter_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_strb,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_strb,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_strb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a request (req plus its we/strb/addr/wdata, held stable by the
  // requester) is consumed on the rising edge where req && gnt are both high;
  // gnt may rise in the same cycle as req. Responses (rvalid) have no ready.
  logic last_gnt;
  logic rd_pend;
  logic rd_id;

  // Grants are held off while reset is asserted.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst) begin
      if (p0_req && p1_req) begin
        if ((FIXED_PRIO != 0) || last_gnt) p0_gnt = 1'b1;
        else                               p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    mem_en    = p0_gnt | p1_gnt;
    mem_we    = 1'b0;
    mem_strb  = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_strb  = p0_we ? p0_strb : 4'b0000;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_strb  = p1_we ? p1_strb : 4'b0000;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= 1'b1;
      rd_pend  <= 1'b0;
      rd_id    <= 1'b0;
    end else begin
      if (mem_en) last_gnt <= p1_gnt;
      rd_pend <= mem_en && !mem_we;
      if (mem_en && !mem_we) rd_id <= p1_gnt;
    end
  end

  // Read data is only exposed to the port whose read is completing.
  always_comb begin
    p0_rvalid = rd_pend && (rd_id == 1'b0);
    p1_rvalid = rd_pend && (rd_id == 1'b1);
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Directed bench for otter_dmem_arbiter: round-robin instance on a small RAM
// model plus a fixed-priority instance sharing the same requester inputs.
module tb_otter_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [3:0]  p0_strb, p1_strb;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid;
  logic [31:0] f_p0_rdata, f_p1_rdata;
  logic        f_mem_en, f_mem_we;
  logic [3:0]  f_mem_strb;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:63];

  otter_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_strb(p0_strb), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_strb(p1_strb), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  otter_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_strb(p0_strb), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_strb(p1_strb), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_strb(f_mem_strb), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign f_mem_rdata = 32'h0;

  // RAM model: loaded while in reset, synchronous byte-write, 1-cycle read
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4]    <= 32'hDEADBEEF;
      ram[8]    <= 32'h11223344;
      ram[12]   <= 32'hA0A00001;
      ram[13]   <= 32'hB1B10002;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_strb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_p0(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_strb = strb; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_strb = strb; p1_addr = addr; p1_wdata = wdata;
  endtask

  // Scoreboard of read data expected on the round-robin instance
  logic [31:0] exp_q[$];

  initial begin
    logic        exp0;
    logic [31:0] exp_d;
    rst = 1'b0;
    drive_p0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Held in reset with p0 requesting
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_p0_gnt", p0_gnt, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
      chk("rst_fp_gnt", {f_p0_gnt, f_p1_gnt}, 2'b00);
    end

    // Release: zero-wait grant of a p0 read with strobes forced off
    @(negedge clk); rst = 1'b1; #1;
    chk("rd_p0_gnt", {p0_gnt, p1_gnt}, 2'b10);
    chk("rd_mem_en", mem_en, 1'b1);
    chk("rd_mem_we", mem_we, 1'b0);
    chk("rd_mem_strb", mem_strb, 4'b0000);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_rvalid_early", p0_rvalid, 1'b0);

    // Byte write from p1; p0 read data returns in the same cycle
    @(negedge clk);
    drive_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_p1(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00);
    #1;
    chk("rd_p0_rvalid", {p0_rvalid, p1_rvalid}, 2'b10);
    chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rdata_zero", p1_rdata, 32'h0);
    chk("wr_p1_gnt", {p0_gnt, p1_gnt}, 2'b01);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_strb", mem_strb, 4'b0010);
    chk("wr_mem_wdata", mem_wdata, 32'h0000AB00);
    chk("wr_mem_addr", mem_addr, 32'h20);

    // Read back the merged word; strobes on a read must not reach the RAM
    @(negedge clk);
    drive_p1(1'b1, 1'b0, 4'hF, 32'h20, 32'hFFFFFFFF);
    #1;
    chk("wr_no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
    chk("rb_p1_gnt", p1_gnt, 1'b1);
    chk("rb_mem_we", mem_we, 1'b0);
    chk("rb_mem_strb", mem_strb, 4'b0000);

    @(negedge clk);
    drive_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rb_p1_rvalid", {p0_rvalid, p1_rvalid}, 2'b01);
    chk("rb_p1_rdata", p1_rdata, 32'h1122AB44);
    chk("idle_mem_en", mem_en, 1'b0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    chk("idle_mem_strb", mem_strb, 4'b0000);

    // Contention: last grant was p1, so round-robin alternates 0,1,0,1,0,1
    // while the fixed-priority instance gives p0 every cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_p0(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
      drive_p1(1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
      #1;
      exp0 = (i % 2 == 0);
      chk("rr_gnt", {p0_gnt, p1_gnt}, {exp0, ~exp0});
      chk("rr_mem_addr", mem_addr, exp0 ? 32'h30 : 32'h34);
      chk("fp_gnt", {f_p0_gnt, f_p1_gnt}, 2'b10);
      if (i > 0) begin
        exp_d = exp_q.pop_front();
        chk("rr_rvalid", {p0_rvalid, p1_rvalid}, {~exp0, exp0});
        chk("rr_rdata", exp0 ? p1_rdata : p0_rdata, exp_d);
      end
      exp_q.push_back(exp0 ? 32'hA0A00001 : 32'hB1B10002);
    end

    // p0 drops: p1 wins on both instances; last p1 read returns
    @(negedge clk);
    drive_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("fp_p1_after_drop", {f_p0_gnt, f_p1_gnt}, 2'b01);
    chk("rr_p1_after_drop", {p0_gnt, p1_gnt}, 2'b01);
    exp_d = exp_q.pop_front();
    chk("rr_last_rvalid", {p0_rvalid, p1_rvalid}, 2'b01);
    chk("rr_last_rdata", p1_rdata, exp_d);
    exp_q.push_back(32'hB1B10002);

    @(negedge clk);
    drive_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    exp_d = exp_q.pop_front();
    chk("drop_rvalid", {p0_rvalid, p1_rvalid}, 2'b01);
    chk("drop_rdata", p1_rdata, exp_d);

    // Reset during an outstanding p1 read drops its response
    @(negedge clk);
    drive_p1(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    #1;
    chk("mid_p1_gnt", p1_gnt, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    drive_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("mid_rvalid_dropped", {p0_rvalid, p1_rvalid}, 2'b00);

    @(negedge clk);
    rst = 1'b1;
    drive_p0(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    drive_p1(1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
    #1;
    chk("post_rst_gnt", {p0_gnt, p1_gnt}, 2'b10);
    chk("post_rst_no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);

    @(negedge clk);
    drive_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("post_rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b10);
    chk("post_rst_rdata", p0_rdata, 32'hA0A00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_dmem_arbiter.md
Name: otter_dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters: port 0 (MCU data port) and port 1 (DMA/debug master).
- Issues at most one RAM access per cycle. Arbitration is round-robin, or fixed priority to port 0 when configured.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between otter_mcu/DMA and the dmem array inside the SoC.

Parameters:
- ADDR_W, 32, byte-address width of requester and RAM ports
- DATA_W, 32, data width; must be 32 (strobe is 4 bits)
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- p0_req  input  1  port 0 request valid
- p0_we  input  1  port 0 write (1) / read (0)
- p0_strb  input  4  port 0 byte write strobes
- p0_addr  input  ADDR_W  port 0 byte address
- p0_wdata  input  DATA_W  port 0 write data
- p0_gnt  output  1  port 0 request accepted this cycle (comb.)
- p0_rvalid  output  1  port 0 read data valid (registered)
- p0_rdata  output  DATA_W  port 0 read data
- p1_req, p1_we, p1_strb, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable
- mem_strb  output  4  RAM byte strobes
- mem_addr  output  ADDR_W  RAM byte address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset (rst=0, asynchronous):
  - last_gnt <= 1, so port 0 wins first.
  - rd_pend <= 0, rd_id <= 0.
  - p0_rvalid = p1_rvalid = 0.
  - With no requests: all gnt = 0, mem_en = 0, mem_we = 0, mem_strb = 0.
- Grant logic (combinational from req and last_gnt):
  - Only p0_req: p0_gnt = 1. Only p1_req: p1_gnt = 1.
  - Both: FIXED_PRIO=1 gives port 0. FIXED_PRIO=0 grants the port not equal to last_gnt.
  - Never both gnt high in the same cycle.
- Handshake:
  - A request is consumed on the clk edge where req && gnt.
  - The requester holds req/addr/we/strb/wdata stable until gnt.
  - gnt may assert in the same cycle req rises (zero-wait when uncontended).
- RAM drive:
  - mem_en = p0_gnt | p1_gnt.
  - mem_we/strb/addr/wdata are muxed from the granted port.
  - With no grant: mem_we = 0, mem_strb = 0, addr/wdata = 0.
  - A read forces mem_strb = 0 regardless of the pX_strb input.
- last_gnt: updates to the granted port id on every grant; holds otherwise.
- Read return:
  - On a granted read: rd_pend <= 1 and rd_id <= granted port. Otherwise rd_pend <= 0.
  - Next cycle, pX_rvalid = rd_pend && rd_id==X, for exactly one cycle.
  - pX_rdata = mem_rdata when pX_rvalid, else 0.
  - No back-pressure on responses; the requester must accept them.
- Throughput: one access per cycle sustained; back-to-back reads from alternating ports return in grant order, each 1 cycle after its grant.
- Write→read same address on consecutive cycles: the read returns the new data (RAM is write-first across cycles; no same-cycle hazard since one access per cycle).
- Reset mid-read: a pending rvalid is dropped and not delivered after reset release.
- Deasserting req before gnt (protocol violation): no access is issued and no state changes.
- Starvation: in round-robin mode, a continuously requesting port waits at most 1 cycle.

Test Plan:
- Reset then idle: rst=0 for 3 cycles with p0_req=1 → gnt=0, rvalid=0, mem_en=0 during reset. First cycle after release → p0_gnt=1.
- Single read: p0 read addr 0x10, RAM word 0xDEADBEEF → p0_gnt same cycle, mem_en=1, mem_we=0. Next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p1_rvalid=0.
- Contention, round-robin: both request reads continuously for 6 cycles → grants alternate 0,1,0,1,0,1. rvalid follows one cycle later with matching ids and data.
- Fixed priority: FIXED_PRIO=1, both request for 4 cycles → p0_gnt=1 every cycle, p1_gnt=0. p1 is granted the cycle after p0_req drops.
- Byte write then read: p1 write addr 0x20, strb=4'b0010, wdata 0x0000AB00 over initial 0x11223344. Next cycle p1 read → p1_rdata=0x1122AB44. Check mem_strb=0 on the read.
- Reset mid-operation: grant p1 read, assert rst before the next edge → p1_rvalid never pulses. After release, last_gnt=1, so on contention port 0 wins.
